fp_peak_scheduler: RTL
======================

FP_PEAK_SCHEDULER -- requirements
Module: fp_peak_scheduler

Interface
REQ-001 Parameter WIN, default 8, gives the number of samples per detection window (2..256).
REQ-002 Parameter IDXW, default 3, gives the sample-index width; it SHALL equal clog2(WIN).
REQ-003 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 in_valid  input  1  marks an IEEE-754 single-precision sample as present on in_data.
REQ-006 in_data  input  32  carries the sample.
REQ-007 in_ready  output  1  indicates the block accepts a sample this cycle.
REQ-008 cfg_we  input  1  writes cfg_thr into the threshold register.
REQ-009 cfg_thr  input  32  carries the single-precision threshold.
REQ-010 out_valid  output  1  marks a window result as present.
REQ-011 out_ready  input  1  indicates the consumer accepts the result.
REQ-012 out_max  output  32  carries the window maximum sample.
REQ-013 out_idx  output  IDXW  carries the in-window index (0-based) of out_max.
REQ-014 out_above  output  IDXW+1  carries the count of samples strictly greater than the threshold.

Function
REQ-015 The block SHALL instantiate exactly one comparator module (ports a, b, gt, lt, eq) and time-share it across all comparisons.
REQ-016 The FSM SHALL have four states: IDLE, CMP_THR, CMP_MAX and REPORT.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in REPORT.
REQ-018 IDLE: on in_valid&in_ready (accept cycle C0), the block SHALL latch in_data into s_reg and go to CMP_THR.
REQ-019 CMP_THR (C1): the comparator SHALL see a=s_reg, b=thr_reg; if gt, above_cnt SHALL increment; the next state SHALL be CMP_MAX.
REQ-020 CMP_MAX (C2): the comparator SHALL see a=s_reg, b=max_reg; if this is the first sample of the window, or gt is set, then max_reg<=s_reg and max_idx<=cnt.
REQ-021 In CMP_MAX, if cnt==WIN-1 the next state SHALL be REPORT; otherwise cnt SHALL increment and the next state SHALL be IDLE.
REQ-022 Throughput SHALL be one sample per 3 cycles; out_valid SHALL rise in C3 of the last sample.
REQ-023 REPORT: out_max, out_idx and out_above SHALL stay stable until out_valid&out_ready.
REQ-024 On the out_valid&out_ready handshake, cnt, above_cnt and the first-sample flag SHALL clear and the next state SHALL be IDLE; in_ready SHALL return in the following cycle.
REQ-025 Ties (eq) SHALL neither count as above nor replace the max; the first occurrence wins.
REQ-026 Ordering SHALL be exactly that of the comparator (sign, then exponent, then mantissa; bitwise-equal only is eq; -0 < +0); NaN handling is out of scope.
REQ-027 cfg_we SHALL update thr_reg at any state; a write in a CMP_THR cycle SHALL NOT affect that cycle's comparison.
REQ-028 in_valid SHALL be ignored outside IDLE; samples SHALL NOT be dropped or buffered.

Reset
REQ-029 While rst_n=0: state=IDLE, cnt=0, above_cnt=0, first flag set, s_reg=max_reg=thr_reg=0x00000000, max_idx=0, out_valid=0; out_max, out_idx and out_above SHALL read 0.
REQ-030 Reset asserted mid-window SHALL discard the partial window; the next accepted sample SHALL be index 0.

Verification
REQ-031 Threshold 0x3F800000; samples 0.5, 2.0, 3.0, -1.0, 3.0, 1.0, 0.25, 2.5 -> out_max=0x40400000, out_idx=2, out_above=4.
REQ-032 Threshold 0x00000000; seven samples 0xC0000000 and 0xBF000000 at index 5 -> out_max=0xBF000000, out_idx=5, out_above=0.
REQ-033 Hold in_valid high continuously -> in_ready is high exactly 1 of every 3 cycles; out_valid rises 3 cycles after the 8th accept.
REQ-034 Hold out_ready low 10 cycles in REPORT -> outputs stay stable, in_ready=0, and in_valid is ignored; after the handshake, the next window starts with fresh counts.
REQ-035 Pulse rst_n low during CMP_MAX of sample 4 -> all outputs are 0; a following 8-sample window reports correct indices from 0.
REQ-036 Write cfg_thr=0x40000000 in the CMP_THR cycle of a 3.0 sample after thr=0x40800000 -> that sample is not counted; the next 3.0 sample is counted.

Source files
------------

// File: rtl/fp_peak_scheduler.sv
// Windowed single-precision peak finder: one shared comparator is time-shared
// between the threshold test and the running-max test, one sample per 3 cycles.
module fp_peak_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        lt,
  output logic        eq
);
  logic [31:0] ka, kb;

  // Map to an unsigned key: negatives invert, positives set the top bit, so -0 < +0
  assign ka = a[31] ? ~a : {1'b1, a[30:0]};
  assign kb = b[31] ? ~b : {1'b1, b[30:0]};
  assign gt = ka > kb;
  assign lt = ka < kb;
  assign eq = a == b;
endmodule

module fp_peak_scheduler #(
  parameter int WIN  = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  output logic            in_ready,
  input  logic            cfg_we,
  input  logic [31:0]     cfg_thr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_max,
  output logic [IDXW-1:0] out_idx,
  output logic [IDXW:0]   out_above
);
  typedef enum logic [1:0] {IDLE, CMP_THR, CMP_MAX, REPORT} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(WIN - 1);

  state_t          state;
  logic [31:0]     s_reg, max_reg, thr_reg;
  logic [IDXW-1:0] cnt, max_idx;
  logic [IDXW:0]   above_cnt;
  logic            first;

  logic [31:0] cmp_b;
  logic        cmp_gt, cmp_lt, cmp_eq, cmp_win, take_max;

  assign cmp_b    = (state == CMP_THR) ? thr_reg : max_reg;
  // Strict win only: a tie never counts and never displaces an earlier max
  assign cmp_win  = cmp_gt & ~cmp_lt & ~cmp_eq;
  assign take_max = first | cmp_win;

  fp_peak_cmp u_cmp (
    .a  (s_reg),
    .b  (cmp_b),
    .gt (cmp_gt),
    .lt (cmp_lt),
    .eq (cmp_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s_reg     <= '0;
      max_reg   <= '0;
      thr_reg   <= '0;
      cnt       <= '0;
      max_idx   <= '0;
      above_cnt <= '0;
      first     <= 1'b1;
      out_max   <= '0;
      out_idx   <= '0;
      out_above <= '0;
    end else begin
      if (cfg_we) thr_reg <= cfg_thr;
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_reg    <= in_data;
            in_ready <= 1'b0;
            state    <= CMP_THR;
          end
        end
        CMP_THR: begin
          if (cmp_win) above_cnt <= above_cnt + 1'b1;
          state <= CMP_MAX;
        end
        CMP_MAX: begin
          first <= 1'b0;
          if (take_max) begin
            max_reg <= s_reg;
            max_idx <= cnt;
          end
          if (cnt == LAST) begin
            // Capture the final result directly so the outputs are valid in REPORT
            out_max   <= take_max ? s_reg : max_reg;
            out_idx   <= take_max ? cnt : max_idx;
            out_above <= above_cnt;
            out_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            cnt      <= cnt + 1'b1;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        REPORT: begin
          if (out_ready) begin
            cnt       <= '0;
            above_cnt <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
